router_output_allocator: RTL and testbench

//  Per-output-port wormhole allocator and credit tracker for the NoC router; one instance per output port.

---
 rtl/router_pkg.sv | 19 +
 rtl/rr_priority_arbiter.sv | 28 ++
 rtl/router_output_allocator.sv | 119 +++++++++++
 tb/tb_router_output_allocator.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared router types and helpers.
// Used by the per-output allocators and arbiters.
package router_pkg;

   typedef enum logic {
      ALLOC_IDLE,
      ALLOC_LOCKED
   } alloc_state_e;

   function automatic logic [31:0] onehot_to_idx(input logic [31:0] oh);
      logic [31:0] idx;
      idx = '0;
      for (int i = 0; i < 32; i++) begin
         if (oh[i]) idx = idx | 32'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_priority_arbiter.sv
// Combinational rotating-priority arbiter.
// Grants the first request at or after ptr, wrapping.
module rr_priority_arbiter #(
   parameter int N  = 5,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt
);

   logic          found;
   logic [PW-1:0] j;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      j     = '0;
      for (int k = 0; k < N; k++) begin
         j = PW'((int'(ptr) + k) % N);
         if (!found && req[j]) begin
            gnt[j] = 1'b1;
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/router_output_allocator.sv
// Per-output wormhole allocator with downstream credit tracking.
// Holds the port for one packet until its tail flit departs.
module router_output_allocator
   import router_pkg::*;
#(
   parameter int NUM_INPUTS        = 5,
   parameter int FLIT_BUFFER_DEPTH = 8,
   localparam int IDX_W = $clog2(NUM_INPUTS),
   localparam int CNT_W = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
   input  logic                  clk_noc,
   input  logic                  rst,
   input  logic [NUM_INPUTS-1:0] req_valid,
   input  logic [NUM_INPUTS-1:0] req_tail,
   input  logic [NUM_INPUTS-1:0] turn_disable,
   input  logic                  credit_in,
   output logic [NUM_INPUTS-1:0] grant,
   output logic [IDX_W-1:0]      grant_idx,
   output logic                  locked,
   output logic [NUM_INPUTS-1:0] flit_pop,
   output logic                  send_out,
   output logic [CNT_W-1:0]      credit_cnt,
   output logic                  credit_err
);

   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FLIT_BUFFER_DEPTH);
   localparam logic [IDX_W-1:0] LAST_C  = IDX_W'(NUM_INPUTS - 1);

   alloc_state_e          state_q, state_d;
   logic [NUM_INPUTS-1:0] grant_q, grant_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]      credit_q, credit_d;
   logic                  cerr_q, cerr_d;

   logic [NUM_INPUTS-1:0] arb_gnt;
   logic [IDX_W-1:0]      arb_idx;
   logic                  fire;

   rr_priority_arbiter #(
      .N  (NUM_INPUTS),
      .PW (IDX_W)
   ) u_arb (
      .req (req_valid & ~turn_disable),
      .ptr (rr_ptr_q),
      .gnt (arb_gnt)
   );

   assign arb_idx = IDX_W'(onehot_to_idx(32'(arb_gnt)));

   // Fire uses the registered count, so a returning credit helps next cycle.
   assign fire = (state_q == ALLOC_LOCKED) && req_valid[idx_q]
              && (credit_q != '0);

   assign grant      = grant_q;
   assign grant_idx  = idx_q;
   assign locked     = (state_q == ALLOC_LOCKED);
   assign flit_pop   = grant_q & {NUM_INPUTS{fire}};
   assign send_out   = fire;
   assign credit_cnt = credit_q;
   assign credit_err = cerr_q;

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      idx_d    = idx_q;
      rr_ptr_d = rr_ptr_q;
      unique case (state_q)
         ALLOC_IDLE: begin
            if (arb_gnt != '0) begin
               state_d = ALLOC_LOCKED;
               grant_d = arb_gnt;
               idx_d   = arb_idx;
            end
         end
         ALLOC_LOCKED: begin
            if (fire && req_tail[idx_q]) begin
               state_d  = ALLOC_IDLE;
               grant_d  = '0;
               idx_d    = '0;
               rr_ptr_d = (idx_q == LAST_C) ? '0 : idx_q + IDX_W'(1);
            end
         end
         default: state_d = ALLOC_IDLE;
      endcase
   end

   always_comb begin
      credit_d = credit_q;
      cerr_d   = cerr_q;
      unique case ({fire, credit_in})
         2'b10: credit_d = credit_q - CNT_W'(1);
         2'b01: begin
            if (credit_q == DEPTH_C) cerr_d = 1'b1;
            else credit_d = credit_q + CNT_W'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_noc or posedge rst) begin
      if (rst) begin
         state_q  <= ALLOC_IDLE;
         grant_q  <= '0;
         idx_q    <= '0;
         rr_ptr_q <= '0;
         credit_q <= DEPTH_C;
         cerr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         idx_q    <= idx_d;
         rr_ptr_q <= rr_ptr_d;
         credit_q <= credit_d;
         cerr_q   <= cerr_d;
      end
   end

endmodule

// File: tb/tb_router_output_allocator.sv
// Directed bench for router_output_allocator.
// Walks reset, arbitration, wormhole hold, credits and mid-packet reset.
module tb_router_output_allocator;

   logic       clk_noc;
   logic       rst;
   logic [4:0] req_valid;
   logic [4:0] req_tail;
   logic [4:0] turn_disable;
   logic       credit_in;
   logic [4:0] grant;
   logic [2:0] grant_idx;
   logic       locked;
   logic [4:0] flit_pop;
   logic       send_out;
   logic [3:0] credit_cnt;
   logic       credit_err;

   int n_cmp;
   int n_bad;
   int sends;

   router_output_allocator #(
      .NUM_INPUTS        (5),
      .FLIT_BUFFER_DEPTH (8)
   ) dut (
      .clk_noc      (clk_noc),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_tail     (req_tail),
      .turn_disable (turn_disable),
      .credit_in    (credit_in),
      .grant        (grant),
      .grant_idx    (grant_idx),
      .locked       (locked),
      .flit_pop     (flit_pop),
      .send_out     (send_out),
      .credit_cnt   (credit_cnt),
      .credit_err   (credit_err)
   );

   initial begin
      clk_noc = 1'b0;
      forever #5 clk_noc = ~clk_noc;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_noc);
      #1;
   endtask

   task automatic refill(input int n);
      credit_in = 1'b1;
      repeat (n) cyc();
      credit_in = 1'b0;
      #1;
   endtask

   initial begin
      logic [4:0] exp_g [4];
      exp_g[0] = 5'b00010;
      exp_g[1] = 5'b01000;
      exp_g[2] = 5'b00010;
      exp_g[3] = 5'b01000;
      n_cmp        = 0;
      n_bad        = 0;
      rst          = 1'b1;
      req_valid    = 5'h1F;
      req_tail     = 5'h00;
      turn_disable = 5'h00;
      credit_in    = 1'b0;

      // T1: reset
      cyc();
      cyc();
      chk("rst_grant", 32'(grant), 32'h0);
      chk("rst_send", 32'(send_out), 32'h0);
      chk("rst_pop", 32'(flit_pop), 32'h0);
      chk("rst_cnt", 32'(credit_cnt), 32'd8);
      chk("rst_err", 32'(credit_err), 32'h0);
      chk("rst_locked", 32'(locked), 32'h0);
      req_valid = 5'h00;
      rst       = 1'b0;

      // T2: round robin between inputs 1 and 3
      req_valid = 5'b01010;
      req_tail  = 5'b01010;
      for (int c = 0; c < 4; c++) begin
         cyc();
         chk("rr_grant", 32'(grant), 32'(exp_g[c]));
         chk("rr_send", 32'(send_out), 32'h1);
         cyc();
         chk("rr_gap", 32'(grant), 32'h0);
      end
      chk("rr_idx_idle", 32'(grant_idx), 32'h0);
      chk("rr_cnt", 32'(credit_cnt), 32'd4);
      req_valid = 5'h00;
      req_tail  = 5'h00;
      refill(4);
      chk("rr_refill", 32'(credit_cnt), 32'd8);

      // T3: wormhole hold, rr_ptr now 4
      req_valid = 5'b00100;
      cyc();
      req_valid = 5'b00101;
      #1;
      chk("wh_grant", 32'(grant), 32'b00100);
      chk("wh_idx", 32'(grant_idx), 32'd2);
      for (int k = 0; k < 4; k++) begin
         if (k == 3) req_tail = 5'b00100;
         #1;
         chk("wh_pop", 32'(flit_pop), 32'b00100);
         cyc();
      end
      req_valid = 5'b00001;
      req_tail  = 5'b00001;
      #1;
      chk("wh_dead", 32'(grant), 32'h0);
      chk("wh_cnt", 32'(credit_cnt), 32'd4);
      cyc();
      chk("wh_next", 32'(flit_pop), 32'b00001);
      cyc();
      req_valid = 5'h00;
      req_tail  = 5'h00;
      #1;
      chk("wh_cnt2", 32'(credit_cnt), 32'd3);
      refill(5);

      // T4: credit stall, 10-flit packet on input 0
      req_valid = 5'b00001;
      cyc();
      sends = 0;
      repeat (11) begin
         #1;
         sends += int'(send_out);
         cyc();
      end
      chk("cs_sends", 32'(sends), 32'd8);
      chk("cs_cnt0", 32'(credit_cnt), 32'd0);
      chk("cs_locked", 32'(locked), 32'h1);
      credit_in = 1'b1;
      #1;
      chk("cs_blocked", 32'(send_out), 32'h0);
      cyc();
      credit_in = 1'b0;
      #1;
      chk("cs_cnt1", 32'(credit_cnt), 32'd1);
      chk("cs_resume", 32'(send_out), 32'h1);
      cyc();
      req_tail  = 5'b00001;
      credit_in = 1'b1;
      cyc();
      credit_in = 1'b0;
      #1;
      chk("cs_tail", 32'(send_out), 32'h1);
      cyc();
      req_valid = 5'h00;
      req_tail  = 5'h00;
      #1;
      chk("cs_idle", 32'(locked), 32'h0);
      refill(3);
      chk("cs_cnt3", 32'(credit_cnt), 32'd3);

      // T5: fire and credit together, then overflow
      req_valid = 5'b00001;
      req_tail  = 5'b00001;
      cyc();
      credit_in = 1'b1;
      #1;
      chk("sim_send", 32'(send_out), 32'h1);
      cyc();
      credit_in = 1'b0;
      req_valid = 5'h00;
      req_tail  = 5'h00;
      #1;
      chk("sim_cnt", 32'(credit_cnt), 32'd3);
      refill(5);
      chk("sim_full", 32'(credit_cnt), 32'd8);
      chk("sim_noerr", 32'(credit_err), 32'h0);
      refill(1);
      chk("ovf_cnt", 32'(credit_cnt), 32'd8);
      chk("ovf_err", 32'(credit_err), 32'h1);
      cyc();
      chk("ovf_sticky", 32'(credit_err), 32'h1);

      // T6: turn disable, then reset mid-packet
      turn_disable = 5'b10000;
      req_valid    = 5'b10000;
      repeat (4) cyc();
      chk("td_grant", 32'(grant), 32'h0);
      chk("td_locked", 32'(locked), 32'h0);
      req_valid = 5'b10100;
      cyc();
      chk("mp_grant", 32'(grant), 32'b00100);
      cyc();
      chk("mp_cnt7", 32'(credit_cnt), 32'd7);
      rst = 1'b1;
      #1;
      chk("mp_locked", 32'(locked), 32'h0);
      chk("mp_pop", 32'(flit_pop), 32'h0);
      chk("mp_cnt", 32'(credit_cnt), 32'd8);
      cyc();
      req_valid = 5'b01001;
      rst       = 1'b0;
      cyc();
      chk("mp_rrptr", 32'(grant), 32'b00001);
      req_valid = 5'h00;
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
